// File: rtl/fetch_control.sv
// Fetch sequencing: imem req/gnt, IF clock enable, PC select and redirects.
// Redirects seen while memory is busy are held until the fetch completes.
package riscv_definitions;
    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        JUMP     = 2'd1,
        TRAP     = 2'd2
    } nextPCType_e;
endpackage

module fetch_control
    import riscv_definitions::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_req,
    input  logic                  ex_jump,
    input  logic [DATA_WIDTH-1:0] ex_jump_addr,
    input  logic                  trap_req,
    input  logic [DATA_WIDTH-1:0] trap_addr,
    output logic                  imem_req,
    input  logic                  imem_gnt,
    output logic                  if_clk_en,
    output nextPCType_e           pc_sel,
    output logic [DATA_WIDTH-1:0] redir_addr,
    output logic                  flush_id
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] FLUSH_LD = 2'(FLUSH_CYCLES);

    state_e                state_q, state_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_trap_q, pend_trap_d;
    logic [DATA_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [1:0]            flush_cnt_q, flush_cnt_d;

    logic                  trap_new;
    logic                  jump_new;
    logic                  cand_valid;
    logic                  cand_trap;
    logic [DATA_WIDTH-1:0] cand_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
            pend_addr_q  <= '0;
            flush_cnt_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_trap_q  <= pend_trap_d;
            pend_addr_q  <= pend_addr_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_trap_d  = pend_trap_q;
        pend_addr_d  = pend_addr_q;
        flush_cnt_d  = (flush_cnt_q != 2'd0) ? flush_cnt_q - 2'd1 : 2'd0;
        imem_req     = 1'b0;
        if_clk_en    = 1'b0;
        pc_sel       = PC_PLUS4;
        redir_addr   = '0;
        flush_id     = 1'b0;
        trap_new     = 1'b0;
        jump_new     = 1'b0;
        cand_valid   = 1'b0;
        cand_trap    = 1'b0;
        cand_addr    = ex_jump_addr;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                imem_req = 1'b1;
                // A pending trap is never displaced; a pending jump blocks jumps.
                trap_new = trap_req && !(pend_valid_q && pend_trap_q);
                jump_new = ex_jump && !trap_req && !pend_valid_q;

                if (trap_new) begin
                    cand_valid = 1'b1;
                    cand_trap  = 1'b1;
                    cand_addr  = trap_addr;
                end else if (pend_valid_q) begin
                    cand_valid = 1'b1;
                    cand_trap  = pend_trap_q;
                    cand_addr  = pend_addr_q;
                end else if (jump_new) begin
                    cand_valid = 1'b1;
                    cand_addr  = ex_jump_addr;
                end

                redir_addr = cand_addr;
                flush_id   = trap_new || jump_new || pend_valid_q
                          || (flush_cnt_q != 2'd0);

                if (imem_gnt) begin
                    if (cand_valid) begin
                        if_clk_en    = 1'b1;
                        pc_sel       = cand_trap ? TRAP : JUMP;
                        pend_valid_d = 1'b0;
                        flush_cnt_d  = FLUSH_LD;
                    end else begin
                        if_clk_en = !stall_req;
                    end
                end else if (cand_valid) begin
                    pend_valid_d = 1'b1;
                    pend_trap_d  = cand_trap;
                    pend_addr_d  = cand_addr;
                end
            end
        endcase
    end

endmodule

// File: doc/fetch_control.md
Name: fetch_control

Overview:
Sequences the instruction_fetch stage. Drives its clk_en, pc_sel and redirect address, and runs the req/gnt handshake with a wait-state instruction memory. Captures jump/trap redirects that arrive while memory is busy and applies them when the fetch completes. Generates flush_id so that wrong-path instructions in IF/ID become NOPs. Sits between the IF stage, the EX-stage branch unit, the trap unit and the hazard unit.

Parameters:
DATA_WIDTH, 32, width of addresses.
FLUSH_CYCLES, 2, cycles flush_id stays high after a redirect is applied (legal 1..3).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
stall_req  input  1  hazard-unit stall request (load-use)
ex_jump  input  1  taken branch/jump from EX, single-cycle pulse
ex_jump_addr  input  DATA_WIDTH  jump target, valid with ex_jump
trap_req  input  1  exception/interrupt request, single-cycle pulse
trap_addr  input  DATA_WIDTH  trap vector, valid with trap_req
imem_req  output  1  instruction memory request
imem_gnt  input  1  memory has inst_data valid this cycle
if_clk_en  output  1  to IF clk_en
pc_sel  output  nextPCType_e (riscv_definitions)  to IF pc_sel
redir_addr  output  DATA_WIDTH  to IF jump_address and trap_address
flush_id  output  1  ID must treat inst_id as NOP

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk. All flops are async-cleared. Reset mid-operation discards pending redirects and the flush count immediately.
- Reset values: state=BOOT, pending_valid=0, flush_cnt=0, imem_req=0, if_clk_en=0, pc_sel=PC_PLUS4, redir_addr=0, flush_id=0.
- State BOOT: held for exactly 1 cycle after reset release. imem_req=0, if_clk_en=0, all inputs ignored. Then go to RUN.
- State RUN: imem_req=1 every cycle. All remaining outputs are combinational from state, registers and inputs (zero latency).
- Redirect candidate, in priority order:
  - trap_req=1, unless a trap is already pending;
  - else the pending redirect, if pending_valid;
  - else ex_jump=1.
  - A jump arriving while any redirect is pending is ignored (it is wrong-path).
  - A trap arriving while a jump is pending replaces the pending jump (kind and address).
- Completion cycle (imem_gnt=1):
  - If a redirect candidate exists: if_clk_en=1, pc_sel=JUMP or TRAP per kind, redir_addr=candidate address, pending_valid cleared, flush_cnt loaded with FLUSH_CYCLES. Redirect overrides stall_req.
  - Else if stall_req=1: if_clk_en=0, pc_sel=PC_PLUS4. The fetch result is discarded and the same PC is re-requested next cycle.
  - Else: if_clk_en=1, pc_sel=PC_PLUS4.
- Wait cycle (imem_gnt=0):
  - if_clk_en=0 and imem_req stays 1. The PC must not change while a request is outstanding.
  - A redirect candidate arriving this cycle is latched into pending (kind plus address).
  - redir_addr still shows the candidate address.
- With no candidate, redir_addr shows the pending address if pending_valid, else ex_jump_addr.
- flush_id = (new redirect input accepted this cycle) OR pending_valid OR (flush_cnt != 0).
- flush_cnt decrements by 1 each cycle while nonzero, saturating at 0. A new redirect applied reloads it to FLUSH_CYCLES.
- ex_jump and trap_req in the same cycle: the trap wins and the jump is dropped.
- ex_jump and trap_req are ignored during BOOT.

Test Plan:
1. Release reset, imem_gnt=1 constant, no stall -> BOOT cycle with imem_req=0, if_clk_en=0. Then imem_req=1, if_clk_en=1, pc_sel=PC_PLUS4 every cycle, flush_id=0.
2. imem_gnt=0 for 3 cycles, then 1 -> if_clk_en=0 for 3 cycles with imem_req=1 held, then if_clk_en=1 with pc_sel=PC_PLUS4.
3. gnt=1, ex_jump=1, ex_jump_addr=0x100 -> same cycle pc_sel=JUMP, redir_addr=0x100, if_clk_en=1. flush_id high that cycle plus next 2 cycles, then 0.
4. gnt=0, ex_jump pulse with 0x200, gnt rises 2 cycles later -> if_clk_en=0 while waiting, flush_id=1 throughout. On the gnt cycle pc_sel=JUMP, redir_addr=0x200. A second ex_jump with 0x300 during the wait is ignored.
5. Pending jump 0x200, then trap_req with trap_addr=0x4 while gnt=0 -> on gnt, pc_sel=TRAP, redir_addr=0x4. Simultaneous ex_jump=0x80 and trap_req=0x4 with gnt=1 -> TRAP to 0x4.
6. stall_req=1, gnt=1 -> if_clk_en=0. stall_req plus ex_jump=0x40 -> JUMP applied, if_clk_en=1. Assert rst_n=0 with a pending jump -> pending cleared, flush_id=0, BOOT re-entered.
